// File: rtl/shuffle_pipe_pkg.sv
// shuffle_pipe_pkg: shared shuffle op encodings and parameter helpers (package pkg_opengpu)
// Contents: shuffle_op_t (SHFL_IDX/UP/DOWN/XOR, anything else is identity), is_pow2()
package pkg_opengpu;
    typedef enum logic [2:0] {
        SHFL_IDX  = 3'd0,
        SHFL_UP   = 3'd1,
        SHFL_DOWN = 3'd2,
        SHFL_XOR  = 3'd3,
        SHFL_NOP  = 3'd4
    } shuffle_op_t;
    function automatic bit is_pow2(input int v);
        return v > 0 && (v & (v - 1)) == 0;
    endfunction
endpackage

// File: rtl/shuffle_pipe_if.sv
// shuffle_pipe_if: request/result bus of the warp shuffle pipe
// Request: in_valid/in_ready, in_op, in_data, in_idx, in_seg_log2, in_mask, in_tag
// Result: out_valid/out_ready, out_data, out_lane_ok, out_tag; status: busy
interface shuffle_pipe_if #(
    parameter int NUM_LANES = 32,
    parameter int DATA_W    = 32,
    parameter int TAG_W     = 6
);
    import pkg_opengpu::*;
    localparam int IW = $clog2(NUM_LANES);
    localparam int SW = $clog2(IW + 1);
    logic                             in_valid;
    logic                             in_ready;
    shuffle_op_t                      in_op;
    logic [NUM_LANES-1:0][DATA_W-1:0] in_data;
    logic [NUM_LANES-1:0][IW-1:0]     in_idx;
    logic [SW-1:0]                    in_seg_log2;
    logic [NUM_LANES-1:0]             in_mask;
    logic [TAG_W-1:0]                 in_tag;
    logic                             out_valid;
    logic                             out_ready;
    logic [NUM_LANES-1:0][DATA_W-1:0] out_data;
    logic [NUM_LANES-1:0]             out_lane_ok;
    logic [TAG_W-1:0]                 out_tag;
    logic                             busy;
    modport slave (
        input  in_valid, in_op, in_data, in_idx, in_seg_log2, in_mask, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_lane_ok, out_tag, busy
    );
    modport master (
        output in_valid, in_op, in_data, in_idx, in_seg_log2, in_mask, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_lane_ok, out_tag, busy
    );
endinterface

// File: rtl/shuffle_pipe_lane_src.sv
// shuffle_lane_src: per-lane source lane and in-bounds flag for one shuffle destination lane
// Ports: op, lane (destination), idx (lane's own index), off (shared offset), seg_log2 -> src, inb
module shuffle_lane_src import pkg_opengpu::*; #(
    parameter int NUM_LANES = 32,
    localparam int IW = $clog2(NUM_LANES),
    localparam int SW = $clog2(IW + 1),
    localparam int AW = IW + 1
) (
    input  shuffle_op_t   op,
    input  logic [IW-1:0] lane,
    input  logic [IW-1:0] idx,
    input  logic [IW-1:0] off,
    input  logic [SW-1:0] seg_log2,
    output logic [IW-1:0] src,
    output logic          inb
);
    logic [AW-1:0] seg, smask, i, o, loc;
    // One extra bit so loc + off cannot wrap and a full-warp segment is representable
    always_comb begin
        seg   = seg_log2 > SW'(IW) ? AW'(NUM_LANES) : AW'(1) << seg_log2;
        smask = seg - AW'(1);
        i     = {1'b0, lane};
        o     = {1'b0, off};
        loc   = i & smask;
        src   = IW'(op == SHFL_IDX  ? (i & ~smask) | ({1'b0, idx} & smask) :
                    op == SHFL_UP   ? i - o :
                    op == SHFL_DOWN ? i + o :
                    op == SHFL_XOR  ? i ^ (o & smask) : i);
        inb   = op == SHFL_UP   ? loc >= o :
                op == SHFL_DOWN ? loc + o < seg : 1'b1;
    end
endmodule

// File: rtl/shuffle_pipe.sv
// shuffle_pipe: multi-pass warp shuffle, LANES_PER_CYCLE destination lanes resolved per cycle
// Ports: clk, rst (async, active-high), bus (shuffle_pipe_if.slave: request, result, busy)
module shuffle_pipe import pkg_opengpu::*; #(
    parameter int NUM_LANES       = 32,
    parameter int DATA_W          = 32,
    parameter int LANES_PER_CYCLE = 8,
    parameter int TAG_W           = 6
) (
    input logic           clk,
    input logic           rst,
    shuffle_pipe_if.slave bus
);
    localparam int IW         = $clog2(NUM_LANES);
    localparam int SW         = $clog2(IW + 1);
    localparam int NUM_PASSES = NUM_LANES / LANES_PER_CYCLE;
    localparam int PW         = NUM_PASSES > 1 ? $clog2(NUM_PASSES) : 1;
    if (!is_pow2(NUM_LANES) || !is_pow2(LANES_PER_CYCLE) || LANES_PER_CYCLE > NUM_LANES) begin : g_bad_params
        $error("shuffle_pipe: NUM_LANES/LANES_PER_CYCLE must be powers of two with LANES_PER_CYCLE <= NUM_LANES");
    end
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t                           state, state_nx;
    logic [PW-1:0]                    pass;
    logic                             accept, last;
    shuffle_op_t                      op_q;
    logic [NUM_LANES-1:0][DATA_W-1:0] data_q, res_data;
    logic [NUM_LANES-1:0][IW-1:0]     idx_q;
    logic [SW-1:0]                    seg_q;
    logic [NUM_LANES-1:0]             mask_q, res_ok;
    logic [TAG_W-1:0]                 tag_q;
    logic [LANES_PER_CYCLE-1:0][IW-1:0]     lane, src;
    logic [LANES_PER_CYCLE-1:0][DATA_W-1:0] nd;
    logic [LANES_PER_CYCLE-1:0]             inb, nok;
    assign accept = bus.in_valid && bus.in_ready;
    assign last   = pass == PW'(NUM_PASSES - 1);
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_nx;
    always_comb begin
        state_nx = state == IDLE ? (bus.in_valid  ? BUSY : IDLE) :
                   state == BUSY ? (last          ? DONE : BUSY) :
                                   (bus.out_ready ? IDLE : DONE);
    end
    always_ff @(posedge clk or posedge rst)
        if (rst)               pass <= '0;
        else if (accept)       pass <= '0;
        else if (state == BUSY) pass <= pass + 1'b1;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            op_q   <= SHFL_IDX;
            data_q <= '0;
            idx_q  <= '0;
            seg_q  <= '0;
            mask_q <= '0;
            tag_q  <= '0;
        end else if (accept) begin
            op_q   <= bus.in_op;
            data_q <= bus.in_data;
            idx_q  <= bus.in_idx;
            seg_q  <= bus.in_seg_log2;
            mask_q <= bus.in_mask;
            tag_q  <= bus.in_tag;
        end
    for (genvar k = 0; k < LANES_PER_CYCLE; k++) begin : g_lane
        assign lane[k] = IW'(int'(pass) * LANES_PER_CYCLE + k);
        shuffle_lane_src #(.NUM_LANES(NUM_LANES)) u_src (
            .op(op_q), .lane(lane[k]), .idx(idx_q[lane[k]]), .off(idx_q[0]),
            .seg_log2(seg_q), .src(src[k]), .inb(inb[k])
        );
        // Out-of-bounds lanes keep their own value
        assign nd[k]  = inb[k] ? data_q[src[k]] : data_q[lane[k]];
        assign nok[k] = mask_q[lane[k]] && inb[k] && mask_q[src[k]];
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            res_data <= '0;
            res_ok   <= '0;
        end else if (state == BUSY) begin
            for (int k = 0; k < LANES_PER_CYCLE; k++) begin
                res_data[lane[k]] <= nd[k];
                res_ok[lane[k]]   <= nok[k];
            end
        end
    assign bus.in_ready    = state == IDLE;
    assign bus.busy        = state != IDLE;
    assign bus.out_valid   = state == DONE;
    assign bus.out_data    = res_data;
    assign bus.out_lane_ok = res_ok;
    assign bus.out_tag     = tag_q;
endmodule

// File: tb/tb_shuffle_pipe.sv
// tb_shuffle_pipe: directed + random scoreboard bench for shuffle_pipe
module tb_shuffle_pipe;
    import pkg_opengpu::*;
    localparam int N = 32, DW = 32, TW = 6, LPC = 8, IW = 5, SW = 3;
    typedef logic [N-1:0][DW-1:0] vec_t;
    typedef logic [N-1:0][IW-1:0] idx_t;
    typedef struct packed {
        vec_t          data;
        logic [N-1:0]  ok;
        logic [TW-1:0] tag;
    } exp_t;

    logic clk = 0;
    logic rst = 1;
    always #5 clk = ~clk;

    shuffle_pipe_if #(.NUM_LANES(N), .DATA_W(DW), .TAG_W(TW)) bus();
    shuffle_pipe #(.NUM_LANES(N), .DATA_W(DW), .LANES_PER_CYCLE(LPC), .TAG_W(TW)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    exp_t sb[$];
    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Reference model written with division/modulo segment arithmetic
    function automatic exp_t model(input shuffle_op_t op, input vec_t d, input idx_t ix,
                                   input int seg, input logic [N-1:0] m, input logic [TW-1:0] t);
        exp_t r;
        int s, off;
        s = seg > IW ? N : (1 << seg);
        off = int'(ix[0]);
        for (int i = 0; i < N; i++) begin
            int base, loc, src;
            bit inb;
            base = (i / s) * s;
            loc = i % s;
            src = i;
            inb = 1;
            case (op)
                SHFL_IDX:  src = base + int'(ix[i]) % s;
                SHFL_UP:   begin src = i - off; inb = loc >= off; end
                SHFL_DOWN: begin src = i + off; inb = loc + off < s; end
                SHFL_XOR:  src = base + (loc ^ (off % s));
                default:   ;
            endcase
            r.data[i] = inb ? d[src] : d[i];
            r.ok[i] = m[i] && inb && m[src];
        end
        r.tag = t;
        return r;
    endfunction

    task automatic drive(input shuffle_op_t op, input vec_t d, input idx_t ix,
                         input logic [SW-1:0] seg, input logic [N-1:0] m, input logic [TW-1:0] t);
        bus.in_op = op;
        bus.in_data = d;
        bus.in_idx = ix;
        bus.in_seg_log2 = seg;
        bus.in_mask = m;
        bus.in_tag = t;
        bus.in_valid = 1;
        check("in_ready_before_accept", 64'(bus.in_ready), 64'd1);
        sb.push_back(model(op, d, ix, int'(seg), m, t));
    endtask

    task automatic send(input shuffle_op_t op, input vec_t d, input idx_t ix,
                        input logic [SW-1:0] seg, input logic [N-1:0] m, input logic [TW-1:0] t);
        drive(op, d, ix, seg, m, t);
        @(posedge clk);
        #1 bus.in_valid = 0;
    endtask

    task automatic wait_valid(input int lat);
        int c = 0;
        while (!bus.out_valid && c < 20) begin
            @(posedge clk);
            #1 c++;
        end
        check("latency", 64'(c), 64'(lat));
    endtask

    task automatic compare_front(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            check({name, "_scoreboard_nonempty"}, 64'd0, 64'd1);
            return;
        end
        e = sb.pop_front();
        for (int i = 0; i < N; i++)
            check($sformatf("%s_data[%0d]", name, i), 64'(bus.out_data[i]), 64'(e.data[i]));
        check({name, "_lane_ok"}, 64'(bus.out_lane_ok), 64'(e.ok));
        check({name, "_tag"}, 64'(bus.out_tag), 64'(e.tag));
    endtask

    task automatic collect(input string name);
        wait_valid(LPC == 0 ? 0 : N / LPC);
        compare_front(name);
        bus.out_ready = 1;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t ramp();
        vec_t v;
        for (int i = 0; i < N; i++) v[i] = DW'(i);
        return v;
    endfunction

    function automatic idx_t offset_idx(input int o);
        idx_t v = '0;
        v[0] = IW'(o);
        return v;
    endfunction

    initial begin
        vec_t d, d_rand;
        idx_t ix;
        exp_t e;
        bus.in_valid = 0;
        bus.in_op = SHFL_IDX;
        bus.in_data = '0;
        bus.in_idx = '0;
        bus.in_seg_log2 = '0;
        bus.in_mask = '0;
        bus.in_tag = '0;
        bus.out_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_in_ready", 64'(bus.in_ready), 64'd1);
        check("reset_out_data_zero", 64'(bus.out_data === '0), 64'd1);
        check("reset_lane_ok", 64'(bus.out_lane_ok), 64'd0);
        @(negedge clk) rst = 0;
        @(posedge clk);
        #1;

        // Reverse via IDX
        d = ramp();
        for (int i = 0; i < N; i++) ix[i] = IW'(31 - i);
        send(SHFL_IDX, d, ix, 3'd5, '1, 6'd9);
        check("busy_after_accept", 64'(bus.busy), 64'd1);
        wait_valid(4);
        check("idx_lane0_const", 64'(bus.out_data[0]), 64'd31);
        check("idx_lane31_const", 64'(bus.out_data[31]), 64'd0);
        check("idx_ok_const", 64'(bus.out_lane_ok), 64'hFFFF_FFFF);
        compare_front("idx");
        @(posedge clk);
        #1;

        // UP off=3, 8-lane segments
        send(SHFL_UP, d, offset_idx(3), 3'd3, '1, 6'd1);
        wait_valid(4);
        check("up_lane11_data", 64'(bus.out_data[11]), 64'd8);
        check("up_lane11_ok", 64'(bus.out_lane_ok[11]), 64'd1);
        check("up_lane10_ok", 64'(bus.out_lane_ok[10]), 64'd0);
        check("up_lane10_own", 64'(bus.out_data[10]), 64'd10);
        compare_front("up");
        @(posedge clk);
        #1;

        // DOWN off=1, lane 0 inactive
        send(SHFL_DOWN, d, offset_idx(1), 3'd5, 32'hFFFF_FFFE, 6'd2);
        wait_valid(4);
        check("down_lane0_data", 64'(bus.out_data[0]), 64'd1);
        check("down_lane0_ok", 64'(bus.out_lane_ok[0]), 64'd0);
        check("down_lane31_ok", 64'(bus.out_lane_ok[31]), 64'd0);
        check("down_lane31_own", 64'(bus.out_data[31]), 64'd31);
        check("down_lane30_ok", 64'(bus.out_lane_ok[30]), 64'd1);
        compare_front("down");
        @(posedge clk);
        #1;

        // XOR off beyond segment masks to zero; seg_log2 7 clamps to full warp
        send(SHFL_XOR, d, offset_idx(16), 3'd2, '1, 6'd3);
        wait_valid(4);
        check("xor_identity", 64'(bus.out_data === d), 64'd1);
        compare_front("xor_s4");
        @(posedge clk);
        #1;
        send(SHFL_XOR, d, offset_idx(16), 3'd7, '1, 6'd4);
        wait_valid(4);
        check("xor_clamp_lane5", 64'(bus.out_data[5]), 64'd21);
        compare_front("xor_clamp");
        @(posedge clk);
        #1;

        // UP with offset >= segment: all lanes out of bounds
        send(SHFL_UP, d, offset_idx(4), 3'd2, '1, 6'd5);
        collect("up_big_off");

        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < N; i++) begin
                d_rand[i] = DW'($urandom);
                ix[i] = IW'($urandom);
            end
            send(shuffle_op_t'(3'($urandom_range(0, 5))), d_rand, ix, 3'($urandom_range(0, 7)),
                 N'($urandom), TW'($urandom));
            collect($sformatf("rand%0d", r));
        end

        // Back-pressure: hold in_valid and change inputs while result waits
        bus.out_ready = 0;
        drive(SHFL_IDX, d, offset_idx(0), 3'd1, '1, 6'd42);
        e = sb[0];
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) bus.in_data[i] = DW'($urandom);
        bus.in_tag = 6'd7;
        wait_valid(4);
        for (int c = 0; c < 10; c++) begin
            check("stall_data", 64'(bus.out_data === e.data), 64'd1);
            check("stall_ok", 64'(bus.out_lane_ok), 64'(e.ok));
            check("stall_tag", 64'(bus.out_tag), 64'd42);
            check("stall_in_ready", 64'(bus.in_ready), 64'd0);
            check("stall_out_valid", 64'(bus.out_valid), 64'd1);
            @(posedge clk);
            #1;
        end
        compare_front("stall");
        bus.in_valid = 0;
        bus.out_ready = 1;
        @(posedge clk);
        #1;
        for (int c = 0; c < 6; c++) begin
            check("stall_single_result", 64'(bus.out_valid), 64'd0);
            @(posedge clk);
            #1;
        end

        // Reset mid-pass
        send(SHFL_DOWN, d, offset_idx(2), 3'd4, '1, 6'd11);
        @(posedge clk);
        #2 rst = 1;
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_out_data_zero", 64'(bus.out_data === '0), 64'd1);
        check("rst_lane_ok", 64'(bus.out_lane_ok), 64'd0);
        check("rst_tag", 64'(bus.out_tag), 64'd0);
        void'(sb.pop_back());
        @(negedge clk) rst = 0;
        send(SHFL_XOR, d, offset_idx(5), 3'd5, 32'h0F0F_F0F0, 6'd13);
        collect("after_reset");

        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
